// File: rtl/min_select_if.sv
// Handshake bundle for min_select_pipe: packed N-channel sample stream in, selected extreme out.
interface min_select_if #(
   parameter int W = 13,
   parameter int N = 3
);
   logic [N*W-1:0] in_data;
   logic           in_mode;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   out_data;
   logic [2:0]     out_idx;
   logic           out_mode;
   logic           out_valid;
   logic           out_ready;

   modport master (
      output in_data, in_mode, in_valid, out_ready,
      input  in_ready, out_data, out_idx, out_mode, out_valid
   );

   modport slave (
      input  in_data, in_mode, in_valid, out_ready,
      output in_ready, out_data, out_idx, out_mode, out_valid
   );
endinterface

// File: rtl/min_select_pipe.sv
// Pipelined min/max selector over N channels: balanced comparator tree, one register per level.
// Define MIN_SELECT_SIGNED_EN to compare samples as two's-complement instead of unsigned.
module min_select_pipe #(
   parameter int W = 13,
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   min_select_if.slave  s
);
   localparam int LAT = $clog2(N);

   logic stall;
   logic adv;

   // NOTE: in_ready is combinational from the output stage so an out_ready rise frees the pipe in the same cycle.
   assign stall      = s.out_valid & ~s.out_ready;
   assign adv        = ~stall;
   assign s.in_ready = adv;

   // True when candidate b must replace incumbent a; strict compare keeps the lower index on ties.
   function automatic logic take_b(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel_max);
`ifdef MIN_SELECT_SIGNED_EN
      take_b = sel_max ? ($signed(b) > $signed(a)) : ($signed(b) < $signed(a));
`else
      take_b = sel_max ? (b > a) : (b < a);
`endif
   endfunction

   for (genvar l = 0; l <= LAT; l++) begin : lvl
      localparam int C = (N + (1 << l) - 1) >> l;

      logic [W-1:0] val [C];
      logic [2:0]   idx [C];
      logic         mode;
      logic         valid;

      if (l == 0) begin : g_src
         for (genvar e = 0; e < C; e++) begin : g_e
            assign val[e] = s.in_data[e*W +: W];
            assign idx[e] = 3'(e);
         end
         assign mode  = s.in_mode;
         assign valid = s.in_valid;
      end else begin : g_stage
         localparam int P = (N + (1 << (l - 1)) - 1) >> (l - 1);

         logic [W-1:0] nxt_val [C];
         logic [2:0]   nxt_idx [C];

         for (genvar e = 0; e < C; e++) begin : g_e
            if (2*e + 1 < P) begin : g_cmp
               logic pick;
               assign pick       = take_b(lvl[l-1].val[2*e], lvl[l-1].val[2*e+1], lvl[l-1].mode);
               assign nxt_val[e] = pick ? lvl[l-1].val[2*e+1] : lvl[l-1].val[2*e];
               assign nxt_idx[e] = pick ? lvl[l-1].idx[2*e+1] : lvl[l-1].idx[2*e];
            end else begin : g_pass
               assign nxt_val[e] = lvl[l-1].val[2*e];
               assign nxt_idx[e] = lvl[l-1].idx[2*e];
            end
         end

         // NOTE: data registers are reset along with the valids so outputs read 0 during and after reset.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               valid <= 1'b0;
               mode  <= 1'b0;
               for (int k = 0; k < C; k++) begin
                  val[k] <= '0;
                  idx[k] <= '0;
               end
            end else if (adv) begin
               valid <= lvl[l-1].valid;
               mode  <= lvl[l-1].mode;
               for (int k = 0; k < C; k++) begin
                  val[k] <= nxt_val[k];
                  idx[k] <= nxt_idx[k];
               end
            end
         end
      end
   end

   assign s.out_data  = lvl[LAT].val[0];
   assign s.out_idx   = lvl[LAT].idx[0];
   assign s.out_mode  = lvl[LAT].mode;
   assign s.out_valid = lvl[LAT].valid;
endmodule

// File: doc/min_select_pipe.md
MIN_SELECT_PIPE -- requirements
Module: min_select_pipe

Interface
REQ-001 Parameter W, default 13: bit width of each channel sample.
REQ-002 Parameter N, default 3, legal range 2..8: number of input channels.
REQ-003 Derived constant LAT = ceil(log2(N)): number of pipeline stages (N=2 -> 1, N=3..4 -> 2, N=5..8 -> 3).
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_data  input  N*W  packed channel samples; channel k occupies bits [k*W +: W].
REQ-007 in_mode  input  1  per-sample select: 0 = minimum, 1 = maximum.
REQ-008 in_valid  input  1  in_data and in_mode are valid this cycle.
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 out_data  output  W  selected extreme value.
REQ-011 out_idx  output  3  channel index of out_data.
REQ-012 out_mode  output  1  in_mode of the sample, carried through the pipe.
REQ-013 out_valid  output  1  out_data, out_idx and out_mode are valid.
REQ-014 out_ready  input  1  downstream accepts the output this cycle.

Function
REQ-015 A sample SHALL be accepted on a cycle with in_valid=1 and in_ready=1.
REQ-016 A result SHALL be delivered on a cycle with out_valid=1 and out_ready=1.
REQ-017 The comparator tree SHALL be a balanced binary reduction with one register stage per level, LAT stages total.
REQ-018 An odd element at any level SHALL pass to the next level unchanged, with its index.
REQ-019 Comparison SHALL be unsigned on W bits; no widening or truncation of sample values.
REQ-020 Tie rule: on equal values the lower channel index SHALL win, in both modes.
REQ-021 in_mode SHALL travel with its sample; consecutive samples may use different modes with no bubble.
REQ-022 Without stall, the result of a sample accepted in cycle t SHALL appear with out_valid=1 in cycle t+LAT.
REQ-023 Stall condition: stall = out_valid & ~out_ready.
REQ-024 While stall=1, every pipeline register SHALL hold its value and in_ready SHALL be 0.
REQ-025 in_ready = ~stall, combinational; an out_ready rise SHALL allow acceptance in the same cycle.
REQ-026 Throughput SHALL be one sample per cycle when out_ready is held at 1.
REQ-027 Pipeline bubbles SHALL propagate as stage-valid=0 and SHALL NOT produce out_valid.
REQ-028 Results SHALL leave in acceptance order; no sample is dropped or duplicated under any out_ready pattern.
REQ-029 out_idx bits above ceil(log2(N)) SHALL be 0.
REQ-030 in_data and in_mode SHALL be ignored on cycles when in_valid=0 or in_ready=0.

Reset
REQ-031 rst_n low SHALL asynchronously clear all stage-valid flags, out_valid, out_data, out_idx and out_mode to 0.
REQ-032 Reset mid-operation SHALL discard every in-flight sample; no result of a pre-reset sample SHALL appear after release.
REQ-033 in_ready SHALL be 1 during reset and in the first cycle after release.

Configuration
REQ-034 Macro MIN_SELECT_SIGNED_EN defined: all comparisons SHALL treat samples as two's-complement W-bit signed values.
REQ-035 Macro MIN_SELECT_SIGNED_EN undefined: comparisons SHALL be unsigned, as in REQ-019.
REQ-036 The tie rule, latency and handshake SHALL be identical in both builds.

Verification (N=3, W=13, unsigned unless noted)
REQ-037 Min tie: in {5,5,9}, mode 0, out_ready=1 -> out_data=5, out_idx=0, out_valid exactly 2 cycles after acceptance.
REQ-038 Max tie at the top value: in {100,8191,8191}, mode 1 -> out_data=8191, out_idx=1, out_mode=1.
REQ-039 Backpressure: stream 6 back-to-back samples and hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, all 6 results appear in order with correct values.
REQ-040 Mode interleave: samples {7,3,9} mode 0 then {7,3,9} mode 1 on consecutive cycles -> results (3, idx 1) then (9, idx 2) on consecutive cycles.
REQ-041 Reset mid-flight: accept 2 samples, assert rst_n=0 for 1 cycle -> all outputs 0 immediately, and no out_valid until a new sample is accepted.
REQ-042 Signed build (MIN_SELECT_SIGNED_EN): in {1,8191,0}, mode 0 -> out_data=8191 (-1), out_idx=1; the unsigned build gives out_data=0, out_idx=2.
